// File: rtl/stim_pkg.sv
// stim_pkg: shared types and helpers for the AXI stimulus master
package stim_pkg;

    typedef enum logic [1:0] {OP_WRITE, OP_READ, OP_READ_CHECK, OP_END} op_e;

    typedef struct packed {
        op_e         op;
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [15:0] delay;
    } cmd_t;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DELAY, S_ISSUE, S_RESP, S_NEXT, S_DONE} state_e;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;

    // Expand a byte strobe into a bit mask covering the enabled bytes
    function automatic logic [63:0] strb_to_mask(input logic [7:0] strb);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[i*8+:8] = {8{strb[i]}};
        return m;
    endfunction

endpackage

// File: rtl/axi_stim_master_if.sv
// axi_stim_master_if: single-beat AXI4 bus with master/slave views
interface axi_stim_master_if #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned UserWidth = 64
) ();
    logic [IdWidth-1:0]     aw_id;
    logic [AddrWidth-1:0]   aw_addr;
    logic [7:0]             aw_len;
    logic [2:0]             aw_size;
    logic [1:0]             aw_burst;
    logic                   aw_lock;
    logic [3:0]             aw_cache;
    logic [2:0]             aw_prot;
    logic [3:0]             aw_qos;
    logic [3:0]             aw_region;
    logic [5:0]             aw_atop;
    logic [UserWidth-1:0]   aw_user;
    logic                   aw_valid;
    logic                   aw_ready;
    logic [DataWidth-1:0]   w_data;
    logic [DataWidth/8-1:0] w_strb;
    logic                   w_last;
    logic [UserWidth-1:0]   w_user;
    logic                   w_valid;
    logic                   w_ready;
    logic [IdWidth-1:0]     b_id;
    logic [1:0]             b_resp;
    logic [UserWidth-1:0]   b_user;
    logic                   b_valid;
    logic                   b_ready;
    logic [IdWidth-1:0]     ar_id;
    logic [AddrWidth-1:0]   ar_addr;
    logic [7:0]             ar_len;
    logic [2:0]             ar_size;
    logic [1:0]             ar_burst;
    logic                   ar_lock;
    logic [3:0]             ar_cache;
    logic [2:0]             ar_prot;
    logic [3:0]             ar_qos;
    logic [3:0]             ar_region;
    logic [UserWidth-1:0]   ar_user;
    logic                   ar_valid;
    logic                   ar_ready;
    logic [IdWidth-1:0]     r_id;
    logic [DataWidth-1:0]   r_data;
    logic [1:0]             r_resp;
    logic                   r_last;
    logic [UserWidth-1:0]   r_user;
    logic                   r_valid;
    logic                   r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
               aw_region, aw_atop, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
               ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
               aw_region, aw_atop, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
               ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

endinterface

// File: rtl/stim_cmd_table.sv
// stim_cmd_table: command register file, one write port and one async read port
module stim_cmd_table import stim_pkg::*; #(
    parameter int unsigned NumCmds = 16
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [$clog2(NumCmds)-1:0] wr_idx_i,
    input  cmd_t                       wr_cmd_i,
    input  logic [$clog2(NumCmds)-1:0] rd_idx_i,
    output cmd_t                       rd_cmd_o
);
    cmd_t mem_q [NumCmds];

    // Table contents are deliberately not reset
    always_ff @(posedge clk_i) begin
        if (we_i && 32'(wr_idx_i) < NumCmds) mem_q[wr_idx_i] <= wr_cmd_i;
    end

    assign rd_cmd_o = mem_q[rd_idx_i];

endmodule

// File: rtl/axi_stim_master.sv
// axi_stim_master: table-driven single-beat AXI4 stimulus master
module axi_stim_master import stim_pkg::*; #(
    parameter int unsigned AxiAddrWidth  = 64,
    parameter int unsigned AxiDataWidth  = 64,
    parameter int unsigned AxiIdWidth    = 4,
    parameter int unsigned AxiUserWidth  = 64,
    parameter int unsigned NumCmds       = 16,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       cmd_we_i,
    input  logic [$clog2(NumCmds)-1:0] cmd_idx_i,
    input  cmd_t                       cmd_i,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       error_o,
    output logic [$clog2(NumCmds)-1:0] err_idx_o,
    output logic [AxiDataWidth-1:0]    rd_data_o,
    output logic                       rd_valid_o,
    axi_stim_master_if.Master          axi_master
);
    localparam int unsigned IdxW  = $clog2(NumCmds);
    localparam int unsigned StrbW = AxiDataWidth / 8;
    localparam int unsigned ToW   = $clog2(TimeoutCycles + 1);

    state_e                  state_q, state_d;
    logic [IdxW-1:0]         ptr_q, ptr_d, err_idx_q, err_idx_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [ToW-1:0]          to_q, to_d;
    logic                    aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                    error_q, error_d, rd_valid_q, rd_valid_d;
    logic [AxiDataWidth-1:0] rd_data_q, rd_data_d;
    cmd_t                    cmd;
    logic [63:0]             mask64;
    logic                    is_wr, to_hit, err_set, chk_bad;
    logic                    aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic                    unused_resp;

    stim_cmd_table #(.NumCmds(NumCmds)) i_table (
        .clk_i    (clk_i),
        .we_i     (cmd_we_i && state_q == S_IDLE),
        .wr_idx_i (cmd_idx_i),
        .wr_cmd_i (cmd_i),
        .rd_idx_i (ptr_q),
        .rd_cmd_o (cmd)
    );

    assign is_wr   = cmd.op == OP_WRITE;
    assign to_hit  = to_q == ToW'(TimeoutCycles - 1);
    assign mask64  = strb_to_mask(cmd.strb);
    assign chk_bad = cmd.op == OP_READ_CHECK &&
                     ((axi_master.r_data ^ cmd.data[AxiDataWidth-1:0]) & mask64[AxiDataWidth-1:0]) != '0;

    // Valids/readies are gated by reset so they fall as soon as reset is applied
    assign axi_master.aw_valid = rst_ni && state_q == S_ISSUE && is_wr && !aw_done_q;
    assign axi_master.w_valid  = rst_ni && state_q == S_ISSUE && is_wr && !w_done_q;
    assign axi_master.ar_valid = rst_ni && state_q == S_ISSUE && !is_wr;
    assign axi_master.b_ready  = rst_ni && state_q == S_RESP && is_wr;
    assign axi_master.r_ready  = rst_ni && state_q == S_RESP && !is_wr;

    assign aw_hs = axi_master.aw_valid && axi_master.aw_ready;
    assign w_hs  = axi_master.w_valid && axi_master.w_ready;
    assign ar_hs = axi_master.ar_valid && axi_master.ar_ready;
    assign b_hs  = axi_master.b_valid && axi_master.b_ready;
    assign r_hs  = axi_master.r_valid && axi_master.r_ready;

    assign axi_master.aw_id     = '0;
    assign axi_master.aw_addr   = cmd.addr[AxiAddrWidth-1:0];
    assign axi_master.aw_len    = 8'd0;
    assign axi_master.aw_size   = 3'($clog2(StrbW));
    assign axi_master.aw_burst  = BURST_INCR;
    assign axi_master.aw_lock   = 1'b0;
    assign axi_master.aw_cache  = '0;
    assign axi_master.aw_prot   = '0;
    assign axi_master.aw_qos    = '0;
    assign axi_master.aw_region = '0;
    assign axi_master.aw_atop   = '0;
    assign axi_master.aw_user   = '0;
    assign axi_master.w_data    = cmd.data[AxiDataWidth-1:0];
    assign axi_master.w_strb    = cmd.strb[StrbW-1:0];
    assign axi_master.w_last    = 1'b1;
    assign axi_master.w_user    = '0;
    assign axi_master.ar_id     = '0;
    assign axi_master.ar_addr   = cmd.addr[AxiAddrWidth-1:0];
    assign axi_master.ar_len    = 8'd0;
    assign axi_master.ar_size   = 3'($clog2(StrbW));
    assign axi_master.ar_burst  = BURST_INCR;
    assign axi_master.ar_lock   = 1'b0;
    assign axi_master.ar_cache  = '0;
    assign axi_master.ar_prot   = '0;
    assign axi_master.ar_qos    = '0;
    assign axi_master.ar_region = '0;
    assign axi_master.ar_user   = '0;

    assign unused_resp = ^{axi_master.b_id, axi_master.b_user, axi_master.r_id,
                           axi_master.r_last, axi_master.r_user};

    // Sequencer: walks the table, drives one transaction per command, records errors
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        error_d    = error_q;
        err_idx_d  = err_idx_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        err_set    = 1'b0;
        case (state_q)
            S_IDLE: if (start_i) begin
                error_d = 1'b0;
                ptr_d   = '0;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                cnt_d     = cmd.delay;
                state_d   = cmd.op == OP_END ? S_DONE : cmd.delay != 16'd0 ? S_DELAY : S_ISSUE;
            end
            S_DELAY: begin
                cnt_d   = cnt_q - 16'd1;
                state_d = cnt_q == 16'd1 ? S_ISSUE : S_DELAY;
            end
            S_ISSUE: begin
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                if (is_wr ? (aw_done_d && w_done_d) : ar_hs) state_d = S_RESP;
                else if (to_hit) begin
                    err_set = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_RESP: begin
                if (b_hs) begin
                    err_set = axi_master.b_resp != RESP_OKAY;
                    state_d = S_NEXT;
                end else if (r_hs) begin
                    rd_data_d  = axi_master.r_data;
                    rd_valid_d = 1'b1;
                    err_set    = axi_master.r_resp != RESP_OKAY || chk_bad;
                    state_d    = S_NEXT;
                end else if (to_hit) begin
                    err_set = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_NEXT: begin
                ptr_d   = ptr_q == IdxW'(NumCmds - 1) ? ptr_q : ptr_q + 1'b1;
                state_d = ptr_q == IdxW'(NumCmds - 1) ? S_DONE : S_FETCH;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (err_set) begin
            error_d   = 1'b1;
            err_idx_d = error_q ? err_idx_q : ptr_q;
        end
        to_d = state_d != state_q ? '0 : to_q + 1'b1;
    end

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            to_q       <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            error_q    <= 1'b0;
            err_idx_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            to_q       <= to_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            error_q    <= error_d;
            err_idx_q  <= err_idx_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign busy_o     = state_q != S_IDLE;
    assign done_o     = state_q == S_DONE;
    assign error_o    = error_q;
    assign err_idx_o  = err_idx_q;
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

endmodule
